// File: rtl/konami1_clkgen_if.sv
// konami1_clkgen_if: control inputs and E/Q timing outputs of konami1_clkgen.
// master = clock generator side, slave = CPU / testbench side.
interface konami1_clkgen_if;
    logic pause;
    logic stretch;
    logic E;
    logic Q;
    logic fallE_en;
    logic fallQ_en;
    logic riseE_en;
    logic riseQ_en;
    logic cpu_nreset;

    modport master (
        input  pause, stretch,
        output E, Q, fallE_en, fallQ_en, riseE_en, riseQ_en, cpu_nreset
    );

    modport slave (
        output pause, stretch,
        input  E, Q, fallE_en, fallQ_en, riseE_en, riseQ_en, cpu_nreset
    );
endinterface

// File: rtl/konami1_clkgen.sv
// konami1_clkgen: KONAMI-1 quadrature E/Q generator with CPU reset sequencer.
// Optional MRDY stretch in phase 3 is enabled by KONAMI1_CLKGEN_STRETCH_EN.
module konami1_clkgen #(
    parameter int DIV     = 3,
    parameter int RST_CYC = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    konami1_clkgen_if.master   bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PC_MAX = PW'(DIV - 1);
    localparam logic [7:0] RC_MAX = 8'(RST_CYC);

    logic [PW-1:0] pc;
    logic [1:0]    ph;
    logic [1:0]    ph_nxt;
    logic [7:0]    rc;
    logic          tc;
    logic          hold;
    logic          adv;

    // Terminal count, stretch hold and next phase for this CLK.
    always_comb begin
        tc = (pc == PC_MAX) && !bus.pause && !RESET;
`ifdef KONAMI1_CLKGEN_STRETCH_EN
        hold = tc && (ph == 2'd3) && bus.stretch;
`else
        hold = 1'b0;
`endif
        adv    = tc && !hold;
        ph_nxt = adv ? ph + 2'd1 : ph;
    end

`ifndef KONAMI1_CLKGEN_STRETCH_EN
    logic unused_stretch;
    assign unused_stretch = bus.stretch;
`endif

    // Edge strobes fire in the CLK whose rising edge moves the phase.
    assign bus.riseQ_en = adv && (ph == 2'd0);
    assign bus.riseE_en = adv && (ph == 2'd1);
    assign bus.fallQ_en = adv && (ph == 2'd2);
    assign bus.fallE_en = adv && (ph == 2'd3);

    // Prescaler: counts unpaused CLKs, wraps at DIV-1 (also while stretching).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc <= '0;
        end else if (!bus.pause) begin
            pc <= (pc == PC_MAX) ? '0 : pc + 1'b1;
        end
    end

    // Phase register with E/Q decoded from the next phase so they move together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ph    <= 2'd0;
            bus.E <= 1'b0;
            bus.Q <= 1'b0;
        end else begin
            ph    <= ph_nxt;
            bus.E <= ph_nxt[1];
            bus.Q <= ph_nxt[1] ^ ph_nxt[0];
        end
    end

    // CPU reset: count E falls, release on the fall that reaches RST_CYC.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rc             <= 8'd0;
            bus.cpu_nreset <= 1'b0;
        end else if (bus.fallE_en && (rc != RC_MAX)) begin
            rc <= rc + 8'd1;
            if (rc + 8'd1 == RC_MAX) begin
                bus.cpu_nreset <= 1'b1;
            end
        end
    end
endmodule
